// File: rtl/sram_prog_writer.sv
// Write-side master for the external program SRAM: takes a valid/ready word
// stream and writes it to consecutive addresses from BASE_ADDR, then flags done.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no session since reset; strobes inactive
// S_ARMED | in_ready high, waiting for the next program word
// S_SETUP | address/data/CE driven, WE still high
// S_WRITE | WE low for WE_CYCLES cycles (timed by we_cnt down-counter)
// S_HOLD  | WE high again, address/data held for hold time
// S_DONE  | session finished; done held until the next start
module sram_prog_writer #(
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 16,
  parameter int WE_CYCLES = 2,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  output logic              mem_cen,
  output logic              mem_wen,
  output logic              mem_oen,
  output logic              mem_lbn,
  output logic              mem_ubn,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] word_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_SETUP, S_WRITE, S_HOLD, S_DONE
  } state_t;

  localparam int CNT_W = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  WE_LOAD  = CNT_W'(WE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   MAX_CNT  = (ADDR_W+1)'(MAX_WORDS);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  we_cnt, we_cnt_nx;
  logic [ADDR_W-1:0] addr_reg, addr_nx;
  logic [ADDR_W-1:0] count_nx, sram_addr_nx;
  logic [DATA_W-1:0] dq_out_nx;
  logic              last_reg, last_nx;
  logic              busy_nx, done_nx;
  logic              drive_nx;
  logic              reached_max;

  // compare one bit wider so MAX_WORDS == 2^ADDR_W is still reachable
  assign reached_max = (({1'b0, word_count} + 1'b1) == MAX_CNT);

  // this block never reads the SRAM
  assign mem_oen = 1'b1;

  always_comb begin
    state_nx     = state;
    we_cnt_nx    = we_cnt;
    addr_nx      = addr_reg;
    count_nx     = word_count;
    last_nx      = last_reg;
    sram_addr_nx = sram_addr;
    dq_out_nx    = sram_dq_out;
    busy_nx      = busy;
    done_nx      = done;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nx = S_ARMED;
          addr_nx  = BASE;
          count_nx = '0;
          busy_nx  = 1'b1;
          done_nx  = 1'b0;
        end
      end
      S_ARMED: begin
        if (in_valid && in_ready) begin
          state_nx     = S_SETUP;
          sram_addr_nx = addr_reg;
          dq_out_nx    = in_data;
          last_nx      = in_last;
        end
      end
      S_SETUP: begin
        state_nx  = S_WRITE;
        we_cnt_nx = WE_LOAD;
      end
      S_WRITE: begin
        if (we_cnt == '0) state_nx = S_HOLD;
        else              we_cnt_nx = we_cnt - 1'b1;
      end
      S_HOLD: begin
        count_nx = word_count + 1'b1;
        addr_nx  = addr_reg + 1'b1;
        if (last_reg || reached_max) begin
          state_nx = S_DONE;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
        end else begin
          state_nx = S_ARMED;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // strobes are registered decodes of the state being entered
  assign drive_nx = (state_nx == S_SETUP) || (state_nx == S_WRITE) || (state_nx == S_HOLD);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      we_cnt      <= '0;
      addr_reg    <= '0;
      last_reg    <= 1'b0;
      word_count  <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      mem_cen     <= 1'b1;
      mem_wen     <= 1'b1;
      mem_lbn     <= 1'b1;
      mem_ubn     <= 1'b1;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nx;
      we_cnt      <= we_cnt_nx;
      addr_reg    <= addr_nx;
      last_reg    <= last_nx;
      word_count  <= count_nx;
      sram_addr   <= sram_addr_nx;
      sram_dq_out <= dq_out_nx;
      sram_dq_oe  <= drive_nx;
      mem_cen     <= !drive_nx;
      mem_wen     <= (state_nx != S_WRITE);
      mem_lbn     <= !drive_nx;
      mem_ubn     <= !drive_nx;
      in_ready    <= (state_nx == S_ARMED);
      busy        <= busy_nx;
      done        <= done_nx;
    end
  end

endmodule

// File: tb/tb_sram_prog_writer.sv
// Randomized bench for sram_prog_writer: unit 0 uses default parameters,
// unit 1 uses MAX_WORDS=4 / BASE_ADDR=0xFFFFE to exercise the cap and wrap.
module tb_sram_prog_writer;
  localparam int WE = 2;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [1:0]  start_s, in_valid_s, in_last_s, in_ready_s;
  logic [1:0]  sram_dq_oe_s, mem_cen_s, mem_wen_s, mem_oen_s, mem_lbn_s, mem_ubn_s;
  logic [1:0]  busy_s, done_s;
  logic [15:0] in_data_s   [2];
  logic [15:0] sram_dq_out_s [2];
  logic [19:0] sram_addr_s [2];
  logic [19:0] word_count_s [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  sram_prog_writer #(.WE_CYCLES(WE)) dut0 (
    .clk(clk), .reset(reset), .start(start_s[0]), .in_data(in_data_s[0]),
    .in_valid(in_valid_s[0]), .in_last(in_last_s[0]), .in_ready(in_ready_s[0]),
    .sram_addr(sram_addr_s[0]), .sram_dq_out(sram_dq_out_s[0]), .sram_dq_oe(sram_dq_oe_s[0]),
    .mem_cen(mem_cen_s[0]), .mem_wen(mem_wen_s[0]), .mem_oen(mem_oen_s[0]),
    .mem_lbn(mem_lbn_s[0]), .mem_ubn(mem_ubn_s[0]), .busy(busy_s[0]), .done(done_s[0]),
    .word_count(word_count_s[0]));

  sram_prog_writer #(.WE_CYCLES(WE), .BASE_ADDR(20'hFFFFE), .MAX_WORDS(4)) dut1 (
    .clk(clk), .reset(reset), .start(start_s[1]), .in_data(in_data_s[1]),
    .in_valid(in_valid_s[1]), .in_last(in_last_s[1]), .in_ready(in_ready_s[1]),
    .sram_addr(sram_addr_s[1]), .sram_dq_out(sram_dq_out_s[1]), .sram_dq_oe(sram_dq_oe_s[1]),
    .mem_cen(mem_cen_s[1]), .mem_wen(mem_wen_s[1]), .mem_oen(mem_oen_s[1]),
    .mem_lbn(mem_lbn_s[1]), .mem_ubn(mem_ubn_s[1]), .busy(busy_s[1]), .done(done_s[1]),
    .word_count(word_count_s[1]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_reset(input int u);
    check("rst_cen",   mem_cen_s[u], 1);
    check("rst_wen",   mem_wen_s[u], 1);
    check("rst_oen",   mem_oen_s[u], 1);
    check("rst_lbn",   mem_lbn_s[u], 1);
    check("rst_ubn",   mem_ubn_s[u], 1);
    check("rst_dq_oe", sram_dq_oe_s[u], 0);
    check("rst_ready", in_ready_s[u], 0);
    check("rst_busy",  busy_s[u], 0);
    check("rst_done",  done_s[u], 0);
    check("rst_count", word_count_s[u], 0);
  endtask

  task automatic start_session(input int u);
    start_s[u] = 1'b1;
    @(negedge clk);
    start_s[u] = 1'b0;
    check("start_busy",  busy_s[u], 1);
    check("start_done",  done_s[u], 0);
    check("start_count", word_count_s[u], 0);
    check("start_ready", in_ready_s[u], 1);
    check("start_cen",   mem_cen_s[u], 1);
  endtask

  // ARMED with no valid word: nothing may be written
  task automatic idle_check(input int u, input int n, input logic [19:0] cnt);
    for (int i = 0; i < n; i++) begin
      check("armed_ready", in_ready_s[u], 1);
      check("armed_cen",   mem_cen_s[u], 1);
      check("armed_wen",   mem_wen_s[u], 1);
      check("armed_oe",    sram_dq_oe_s[u], 0);
      check("armed_count", word_count_s[u], cnt);
      @(negedge clk);
    end
  endtask

  // Offers one word and checks the full SETUP / WRITE / HOLD strobe sequence.
  task automatic send_word(input int u, input logic [15:0] d, input logic last,
                           input logic [19:0] a, input logic [19:0] cnt, input logic fin,
                           input bit poke_start, input bit poke_reset, output int acc);
    int n = 0;
    in_valid_s[u] = 1'b1;
    in_data_s[u]  = d;
    in_last_s[u]  = last;
    while (!in_ready_s[u] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", in_ready_s[u], 1);
    acc = cyc;
    @(negedge clk);
    in_valid_s[u] = 1'b0;
    in_last_s[u]  = 1'b0;
    in_data_s[u]  = 16'($urandom);
    check("setup_ready", in_ready_s[u], 0);
    check("setup_cen",   mem_cen_s[u], 0);
    check("setup_lbn",   mem_lbn_s[u], 0);
    check("setup_wen",   mem_wen_s[u], 1);
    check("setup_oe",    sram_dq_oe_s[u], 1);
    check("setup_addr",  sram_addr_s[u], a);
    check("setup_data",  sram_dq_out_s[u], d);
    for (int i = 0; i < WE; i++) begin
      @(negedge clk);
      if (poke_start) start_s[u] = (i == 0);
      check("write_wen",  mem_wen_s[u], 0);
      check("write_cen",  mem_cen_s[u], 0);
      check("write_ubn",  mem_ubn_s[u], 0);
      check("write_oe",   sram_dq_oe_s[u], 1);
      check("write_addr", sram_addr_s[u], a);
      check("write_data", sram_dq_out_s[u], d);
      if (poke_reset && i == 1) begin
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_reset(u);
        return;
      end
    end
    start_s[u] = 1'b0;
    @(negedge clk);
    check("hold_wen",  mem_wen_s[u], 1);
    check("hold_cen",  mem_cen_s[u], 0);
    check("hold_oen",  mem_oen_s[u], 1);
    check("hold_oe",   sram_dq_oe_s[u], 1);
    check("hold_addr", sram_addr_s[u], a);
    check("hold_data", sram_dq_out_s[u], d);
    @(negedge clk);
    check("post_count", word_count_s[u], cnt);
    check("post_done",  done_s[u], fin);
    check("post_busy",  busy_s[u], !fin);
    check("post_ready", in_ready_s[u], !fin);
    check("post_cen",   mem_cen_s[u], 1);
    check("post_wen",   mem_wen_s[u], 1);
    check("post_oe",    sram_dq_oe_s[u], 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc, prev, len;
    logic last, fin;
    reset = 1'b0;
    start_s = '0; in_valid_s = '0; in_last_s = '0;
    in_data_s[0] = '0; in_data_s[1] = '0;
    repeat (3) @(negedge clk);
    check_reset(0);
    check_reset(1);
    reset = 1'b1;
    @(negedge clk);

    // single word with last
    start_session(0);
    send_word(0, 16'hBEEF, 1'b1, 20'd0, 20'd1, 1'b1, 0, 0, acc);
    repeat (3) begin
      @(negedge clk);
      check("done_hold", done_s[0], 1);
      check("done_cen",  mem_cen_s[0], 1);
    end

    // back-to-back burst: one word every WE+3 cycles
    start_session(0);
    prev = 0;
    for (int i = 0; i < 3; i++) begin
      send_word(0, 16'(i + 1), i == 2, 20'(i), 20'(i + 1), i == 2, 0, 0, acc);
      if (i > 0) check("burst_period", acc - prev, WE + 3);
      prev = acc;
    end

    // backpressure gap and start during WRITE
    start_session(0);
    send_word(0, 16'h1234, 1'b0, 20'd0, 20'd1, 1'b0, 1, 0, acc);
    idle_check(0, 10, 20'd1);
    send_word(0, 16'h5678, 1'b1, 20'd1, 20'd2, 1'b1, 0, 0, acc);

    // MAX_WORDS cap with address wrap
    start_session(1);
    for (int i = 0; i < 4; i++)
      send_word(1, 16'($urandom), 1'b0, 20'(20'hFFFFE + i), 20'(i + 1), i == 3, 0, 0, acc);
    in_valid_s[1] = 1'b1;
    in_data_s[1]  = 16'hAAAA;
    repeat (4) begin
      check("cap_ready", in_ready_s[1], 0);
      check("cap_done",  done_s[1], 1);
      check("cap_count", word_count_s[1], 4);
      check("cap_cen",   mem_cen_s[1], 1);
      @(negedge clk);
    end
    in_valid_s[1] = 1'b0;

    // random sessions against the arithmetic model
    for (int s = 0; s < 4; s++) begin
      len = $urandom_range(1, 6);
      start_session(0);
      for (int i = 0; i < len; i++) begin
        idle_check(0, $urandom_range(0, 3), 20'(i));
        send_word(0, 16'($urandom), i == len - 1, 20'(i), 20'(i + 1), i == len - 1, 0, 0, acc);
      end
    end
    for (int s = 0; s < 4; s++) begin
      len = (s == 0) ? 4 : $urandom_range(1, 6);
      start_session(1);
      for (int i = 0; i < len; i++) begin
        last = (i == len - 1);
        fin  = last || (i + 1 == 4);
        idle_check(1, $urandom_range(0, 2), 20'(i));
        send_word(1, 16'($urandom), last, 20'(20'hFFFFE + i), 20'(i + 1), fin, 0, 0, acc);
        if (fin) break;
      end
      @(negedge clk);
      check("single_done", done_s[1], 1);
    end

    // reset during second WRITE cycle of word 2
    start_session(0);
    send_word(0, 16'hC0DE, 1'b0, 20'd0, 20'd1, 1'b0, 0, 0, acc);
    send_word(0, 16'hD00D, 1'b0, 20'd1, 20'd2, 1'b0, 0, 1, acc);
    repeat (3) begin
      @(negedge clk);
      check("post_rst_cen", mem_cen_s[0], 1);
      check("post_rst_wen", mem_wen_s[0], 1);
    end
    start_session(0);
    send_word(0, 16'h4321, 1'b1, 20'd0, 20'd1, 1'b1, 0, 0, acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_prog_writer.md
Name: sram_prog_writer

Overview:
- Write-side master for the external 16-bit async SRAM that holds GPU program images; it is the counterpart of the scheduler's program-read path.
- Accepts a stream of 16-bit program words over a valid/ready handshake and writes them to consecutive SRAM addresses from a base address.
- Generates the CE/WE/OE/LB/UB strobe sequence and the tristate data-drive enable.
- Signals completion so the scheduler can start fetching.

Parameters:
- ADDR_W, 20, SRAM word-address width.
- DATA_W, 16, SRAM data width.
- WE_CYCLES, 2, number of clk cycles WE_N is held low per write (≥1).
- BASE_ADDR, 0, first SRAM address written after start.
- MAX_WORDS, 1024, maximum words per load; reaching it forces completion.

Ports:
- clk  in  1  system clock (CLOCK_50).
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load session.
- in_data  in  DATA_W  program word.
- in_valid  in  1  in_data/in_last valid.
- in_last  in  1  marks final word of the image.
- in_ready  out  1  writer can accept a word this cycle.
- sram_addr  out  ADDR_W  SRAM address.
- sram_dq_out  out  DATA_W  data driven onto SRAM DQ.
- sram_dq_oe  out  1  1 = drive DQ; the top-level tristate uses it.
- mem_cen  out  1  SRAM CE_N.
- mem_wen  out  1  SRAM WE_N.
- mem_oen  out  1  SRAM OE_N.
- mem_lbn  out  1  SRAM LB_N.
- mem_ubn  out  1  SRAM UB_N.
- busy  out  1  session in progress.
- done  out  1  load complete; level signal.
- word_count  out  ADDR_W  number of words written this session.

Behaviour:
- Reset is synchronous and active-low: it is sampled only on the clk rising edge, with reset==0.
- Reset values:
  - mem_cen = mem_wen = mem_oen = mem_lbn = mem_ubn = 1.
  - sram_dq_oe = 0; sram_addr = 0; sram_dq_out = 0.
  - in_ready = 0; busy = 0; done = 0; word_count = 0.
  - FSM = IDLE.
- mem_oen is constant 1 in every state; this block never reads.
- FSM states and transitions:
  - IDLE: all strobes high, dq_oe = 0. start → ARMED, with addr_reg = BASE_ADDR, word_count = 0, done = 0, busy = 1.
  - ARMED: in_ready = 1. If in_valid & in_ready: latch in_data and in_last, then → SETUP. Without in_valid, stay in ARMED indefinitely.
  - SETUP (1 cycle):
    - in_ready = 0.
    - sram_addr = addr_reg; sram_dq_out = latched data; dq_oe = 1.
    - cen = lbn = ubn = 0; wen = 1.
  - WRITE (WE_CYCLES cycles): as SETUP, with wen = 0. An internal counter counts WE_CYCLES, then → HOLD.
  - HOLD (1 cycle):
    - wen = 1; cen, lbn, ubn, addr, data and dq_oe unchanged (data hold time).
    - On exit: word_count += 1; addr_reg = addr_reg + 1 (mod 2^ADDR_W, wraps silently).
    - If latched in_last = 1, or word_count + 1 == MAX_WORDS → DONE; else → ARMED.
  - DONE: strobes high, dq_oe = 0, busy = 0, done = 1. done holds until the next start, which clears done on the same edge and → ARMED.
- Every output is registered; no output is combinational from inputs.
- Timing: in_ready deasserts the cycle after acceptance. Minimum period is WE_CYCLES + 3 cycles per word (accept, SETUP, WRITE×WE_CYCLES, HOLD).
- sram_addr and sram_dq_out change only in the SETUP cycle. They are stable from SETUP through HOLD.
- A start pulse in ARMED/SETUP/WRITE/HOLD is ignored.
- in_valid while in_ready = 0 is ignored; the source must hold the word until in_ready.
- in_last arriving together with the MAX_WORDS-th word gives a single completion; done asserts once.
- Reset in any state, including mid-WRITE: the next cycle shows reset values. That partial SRAM write is abandoned, and no further strobes are issued until a new start.
- MAX_WORDS = 0 is illegal; WE_CYCLES = 0 is illegal.

Test Plan:
- Reset held low 3 cycles → all strobes 1, dq_oe = 0, in_ready = 0, busy = 0, done = 0, word_count = 0.
- start; word 0xBEEF with in_last = 1, WE_CYCLES = 2:
  - SETUP: addr 0, cen 0, dq_oe 1.
  - 2 cycles with wen = 0, then HOLD with wen = 1 and data still 0xBEEF.
  - done = 1 and word_count = 1 the cycle after HOLD.
- Burst 0x0001, 0x0002, 0x0003 (last on the third), in_valid held high:
  - writes to addr 0, 1, 2.
  - in_ready pulses every 5 cycles.
  - word_count ends at 3.
- Backpressure: in_valid low for 10 cycles between words → FSM stays in ARMED, strobes high, no extra write. start pulsed during WRITE → ignored.
- MAX_WORDS = 4, BASE_ADDR = 0xFFFFE, 6 words without in_last:
  - addresses 0xFFFFE, 0xFFFFF, 0x00000, 0x00001.
  - done after the 4th word; 5th in_valid sees in_ready = 0.
- reset = 0 during the second WRITE cycle of word 2:
  - next cycle wen = 1, cen = 1, dq_oe = 0, word_count = 0.
  - after reset, a new start writes again from BASE_ADDR.
